// File: rtl/quad_encoder_tx_if.sv
// Bus between a target source and the quadrature encoder emulator.
// The master issues load/target; the slave returns phases, position and status.
interface quad_encoder_tx_if #(
   parameter int unsigned POS_W = 6
);
   logic [POS_W-1:0] target;
   logic             load;
   logic             enc_a;
   logic             enc_b;
   logic             enc_c;
   logic [POS_W-1:0] position;
   logic             busy;
   logic             done;

   modport master (
      output target, load,
      input  enc_a, enc_b, enc_c, position, busy, done
   );

   modport slave (
      input  target, load,
      output enc_a, enc_b, enc_c, position, busy, done
   );
endinterface

// File: rtl/quad_encoder_tx.sv
// Quadrature encoder emulator: walks A/B phases from the current position to a
// commanded target by the shortest path, one phase edge every CLK_DIV clocks.
// Optional index output enabled by defining QUAD_ENCODER_TX_INDEX_EN.
module quad_encoder_tx #(
   parameter int unsigned CLK_DIV = 1563,
   parameter int unsigned POS_W   = 6
) (
   input logic              clk,
   input logic              reset_n,
   quad_encoder_tx_if.slave bus
);
   localparam int unsigned PRE_W = $clog2(CLK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [POS_W-1:0] HALF = POS_W'(1) << (POS_W - 1);

   typedef enum logic [0:0] {IDLE, RUN} state_e;

   state_e           state_q, state_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [1:0]       ph_q, ph_d;       // {a, b}
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] tgt_q, tgt_d;
   logic             up_q, up_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [POS_W-1:0] eff_tgt;
   logic [1:0]       ph_step;
   logic [POS_W-1:0] pos_step;

   // Shortest path modulo 2^POS_W; the exact half-way tie goes upward.
   function automatic logic dir_up(input logic [POS_W-1:0] tgt,
                                   input logic [POS_W-1:0] pos);
      logic [POS_W-1:0] d;
      d = tgt - pos;
      return (d != '0) && (d <= HALF);
   endfunction

   // Next-state: prescaler, phase stepping, count boundaries and retargeting.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      ph_d    = ph_q;
      pos_d   = pos_q;
      tgt_d   = tgt_q;
      up_d    = up_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      // A load coinciding with a completing tick wins that tick's compare.
      eff_tgt  = bus.load ? bus.target : tgt_q;
      ph_step  = up_q ? {~ph_q[0], ph_q[1]} : {ph_q[0], ~ph_q[1]};
      pos_step = up_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

      case (state_q)
         IDLE: begin
            if (bus.load) begin
               if (bus.target != pos_q) begin
                  tgt_d   = bus.target;
                  up_d    = dir_up(bus.target, pos_q);
                  presc_d = '0;
                  busy_d  = 1'b1;
                  state_d = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.load) tgt_d = bus.target;
            if (presc_q == PRE_LAST) begin
               presc_d = '0;
               ph_d    = ph_step;
               // Direction only changes once the phase is back at 00.
               if (ph_step == 2'b00) begin
                  pos_d = pos_step;
                  if (pos_step == eff_tgt) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     up_d = dir_up(eff_tgt, pos_step);
                  end
               end
            end else begin
               presc_d = presc_q + PRE_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset snaps the phase back to 00.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         presc_q <= '0;
         ph_q    <= 2'b00;
         pos_q   <= '0;
         tgt_q   <= '0;
         up_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         ph_q    <= ph_d;
         pos_q   <= pos_d;
         tgt_q   <= tgt_d;
         up_q    <= up_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef QUAD_ENCODER_TX_INDEX_EN
   logic enc_c_q;

   // Index marks position 0 with the phase at rest, one cycle late.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) enc_c_q <= 1'b0;
      else          enc_c_q <= (pos_q == '0) && (ph_q == 2'b00);
   end

   assign bus.enc_c = enc_c_q;
`else
   assign bus.enc_c = 1'b0;
`endif

   assign bus.enc_a    = ph_q[1];
   assign bus.enc_b    = ph_q[0];
   assign bus.position = pos_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule
